// File: rtl/shifter_pkg.sv
// Shared mode/direction encodings and latency helper for the shifter_pipe datapath.
package shifter_pkg;

    typedef enum logic [1:0] {
        ModeLogical = 2'b00,
        ModeArith   = 2'b01,
        ModeRotate  = 2'b10,
        ModeRsvd    = 2'b11
    } sh_mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Pipeline depth: one register per REG_EVERY stages, rounded up.
    function automatic int unsigned lat_calc(input int unsigned width,
                                             input int unsigned reg_every);
        int unsigned amt_w;
        amt_w = $clog2(width);
        return (amt_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One combinational barrel-shifter stage: shifts by 2**K when enabled and folds in overflow.
// Rotate wrap exists only when SHIFTER_PIPE_ROTATE_EN is defined; otherwise ROTATE acts as LOGICAL.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned K     = 0
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ovf,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic             i_en,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data,
    output logic             o_ovf
);
    localparam int unsigned S = 1 << K;

    logic         w_rot;
    logic         w_arith;
    logic [S-1:0] w_fill;
    logic [S-1:0] w_lost;

`ifdef SHIFTER_PIPE_ROTATE_EN
    assign w_rot = (i_mode == ModeRotate);
`else
    assign w_rot = 1'b0;
`endif
    assign w_arith = (i_mode == ModeArith);
    assign w_lost  = i_data[WIDTH-1 -: S];

    always_comb begin
        o_data = i_data;
        o_ovf  = i_ovf;
        w_fill = '0;
        if (i_en) begin
            if (i_dir == DIR_RIGHT) begin
                if (w_rot) begin
                    w_fill = i_data[S-1:0];
                end else if (w_arith) begin
                    w_fill = {S{i_sign}};
                end
                o_data = {w_fill, i_data[WIDTH-1:S]};
            end else begin
                if (w_rot) begin
                    w_fill = w_lost;
                end
                o_data = {i_data[WIDTH-1-S:0], w_fill};
                // Arith overflow: any dropped bit or the new MSB disagrees with the original sign.
                if (w_arith) begin
                    o_ovf = i_ovf | (|(w_lost ^ {S{i_sign}})) | (i_data[WIDTH-1-S] != i_sign);
                end else if (!w_rot) begin
                    o_ovf = i_ovf | (|w_lost);
                end
            end
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides and a global-advance stall.
// Optional rotate wrap is enabled by defining SHIFTER_PIPE_ROTATE_EN.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned AMT_W     = $clog2(WIDTH),
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_sh_dir,
    input  logic [1:0]       i_sh_mode,
    input  logic [AMT_W-1:0] i_sh_amt,
    input  logic [WIDTH-1:0] i_d_in,
    input  logic [TAG_W-1:0] i_tag_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_ovf,
    output logic [TAG_W-1:0] o_tag_out
);
    localparam int unsigned LAT = lat_calc(WIDTH, REG_EVERY);

    // Node k is the state entering stage k; node AMT_W is the fully shifted result.
    logic [WIDTH-1:0] w_nd_data [AMT_W+1];
    logic             w_nd_ovf  [AMT_W+1];
    logic             w_nd_dir  [AMT_W+1];
    logic [1:0]       w_nd_mode [AMT_W+1];
    logic [AMT_W-1:0] w_nd_amt  [AMT_W+1];
    logic             w_nd_sign [AMT_W+1];
    logic [TAG_W-1:0] w_nd_tag  [AMT_W+1];
    logic             w_nd_vld  [AMT_W+1];

    logic [WIDTH-1:0] w_ld_data [LAT];
    logic             w_ld_ovf  [LAT];
    logic             w_ld_dir  [LAT];
    logic [1:0]       w_ld_mode [LAT];
    logic [AMT_W-1:0] w_ld_amt  [LAT];
    logic             w_ld_sign [LAT];
    logic [TAG_W-1:0] w_ld_tag  [LAT];
    logic             w_ld_vld  [LAT];

    logic [WIDTH-1:0] r_data [LAT];
    logic             r_ovf  [LAT];
    logic             r_dir  [LAT];
    logic [1:0]       r_mode [LAT];
    logic [AMT_W-1:0] r_amt  [LAT];
    logic             r_sign [LAT];
    logic [TAG_W-1:0] r_tag  [LAT];
    logic             r_vld  [LAT];

    logic w_adv;
    logic w_unused;

    assign w_adv      = !r_vld[LAT-1] || i_out_ready;
    assign o_in_ready = w_adv;

    assign w_nd_data[0] = i_d_in;
    assign w_nd_ovf[0]  = 1'b0;
    assign w_nd_dir[0]  = i_sh_dir;
    assign w_nd_mode[0] = i_sh_mode;
    assign w_nd_amt[0]  = i_sh_amt;
    assign w_nd_sign[0] = i_d_in[WIDTH-1];
    assign w_nd_tag[0]  = i_tag_in;
    assign w_nd_vld[0]  = i_in_valid;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        logic [WIDTH-1:0] w_src_data;
        logic             w_src_ovf;
        logic             w_src_dir;
        logic [1:0]       w_src_mode;
        logic [AMT_W-1:0] w_src_amt;
        logic             w_src_sign;
        logic [TAG_W-1:0] w_src_tag;
        logic             w_src_vld;

        if (k > 0 && (k % REG_EVERY) == 0) begin : g_from_reg
            localparam int unsigned R = k / REG_EVERY - 1;
            assign w_src_data = r_data[R];
            assign w_src_ovf  = r_ovf[R];
            assign w_src_dir  = r_dir[R];
            assign w_src_mode = r_mode[R];
            assign w_src_amt  = r_amt[R];
            assign w_src_sign = r_sign[R];
            assign w_src_tag  = r_tag[R];
            assign w_src_vld  = r_vld[R];
        end else begin : g_from_node
            assign w_src_data = w_nd_data[k];
            assign w_src_ovf  = w_nd_ovf[k];
            assign w_src_dir  = w_nd_dir[k];
            assign w_src_mode = w_nd_mode[k];
            assign w_src_amt  = w_nd_amt[k];
            assign w_src_sign = w_nd_sign[k];
            assign w_src_tag  = w_nd_tag[k];
            assign w_src_vld  = w_nd_vld[k];
        end

        shifter_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .i_data (w_src_data),
            .i_ovf  (w_src_ovf),
            .i_dir  (w_src_dir),
            .i_mode (w_src_mode),
            .i_en   (w_src_amt[k]),
            .i_sign (w_src_sign),
            .o_data (w_nd_data[k+1]),
            .o_ovf  (w_nd_ovf[k+1])
        );

        assign w_nd_dir[k+1]  = w_src_dir;
        assign w_nd_mode[k+1] = w_src_mode;
        assign w_nd_amt[k+1]  = w_src_amt;
        assign w_nd_sign[k+1] = w_src_sign;
        assign w_nd_tag[k+1]  = w_src_tag;
        assign w_nd_vld[k+1]  = w_src_vld;
    end

    for (genvar j = 0; j < LAT; j++) begin : g_ld
        localparam int unsigned SRC =
            ((j + 1) * REG_EVERY > AMT_W) ? AMT_W : (j + 1) * REG_EVERY;
        assign w_ld_data[j] = w_nd_data[SRC];
        assign w_ld_ovf[j]  = w_nd_ovf[SRC];
        assign w_ld_dir[j]  = w_nd_dir[SRC];
        assign w_ld_mode[j] = w_nd_mode[SRC];
        assign w_ld_amt[j]  = w_nd_amt[SRC];
        assign w_ld_sign[j] = w_nd_sign[SRC];
        assign w_ld_tag[j]  = w_nd_tag[SRC];
        assign w_ld_vld[j]  = w_nd_vld[SRC];
    end

    // Every register, bubbles included, loads or holds together on the global advance.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned j = 0; j < LAT; j++) begin
                r_data[j] <= '0;
                r_ovf[j]  <= 1'b0;
                r_dir[j]  <= 1'b0;
                r_mode[j] <= 2'b00;
                r_amt[j]  <= '0;
                r_sign[j] <= 1'b0;
                r_tag[j]  <= '0;
                r_vld[j]  <= 1'b0;
            end
        end else if (w_adv) begin
            for (int unsigned j = 0; j < LAT; j++) begin
                r_data[j] <= w_ld_data[j];
                r_ovf[j]  <= w_ld_ovf[j];
                r_dir[j]  <= w_ld_dir[j];
                r_mode[j] <= w_ld_mode[j];
                r_amt[j]  <= w_ld_amt[j];
                r_sign[j] <= w_ld_sign[j];
                r_tag[j]  <= w_ld_tag[j];
                r_vld[j]  <= w_ld_vld[j];
            end
        end
    end

    assign o_out_valid = r_vld[LAT-1];
    assign o_d_out     = r_data[LAT-1];
    assign o_ovf       = r_ovf[LAT-1];
    assign o_tag_out   = r_tag[LAT-1];

    assign w_unused = ^{r_dir[LAT-1], r_mode[LAT-1], r_amt[LAT-1], r_sign[LAT-1]};

endmodule
